// File: rtl/pipe_ctrl_pkg.sv
// Shared types and default geometry for the pipeline controller.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } pipe_state_t;

    localparam int STAGES_DEF     = 5;
    localparam int EXC_STAGE_DEF  = 3;
    localparam int SQUASH_CYC_DEF = 1;
    localparam int SQ_CNT_W       = 2;

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Wrapping stall/flush/retire event counters; compiled only when PIPE_CTRL_PERF_EN is defined.
`ifdef PIPE_CTRL_PERF_EN
module pipe_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc_stall,
    input  logic             i_inc_flush,
    input  logic             i_inc_retire,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt,
    output logic [CNT_W-1:0] o_retire_cnt
);

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_retire_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
            r_retire_cnt <= '0;
        end else begin
            if (i_inc_stall)  r_stall_cnt  <= r_stall_cnt + 1'b1;
            if (i_inc_flush)  r_flush_cnt  <= r_flush_cnt + 1'b1;
            if (i_inc_retire) r_retire_cnt <= r_retire_cnt + 1'b1;
        end
    end

    assign o_stall_cnt  = r_stall_cnt;
    assign o_flush_cnt  = r_flush_cnt;
    assign o_retire_cnt = r_retire_cnt;

endmodule
`endif

// File: rtl/pipe_ctrl.sv
// In-order pipeline stall/flush/exception controller.
// Define PIPE_CTRL_PERF_EN to build the performance counters; otherwise perf outputs tie to 0.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STAGES     = STAGES_DEF,
    parameter int EXC_STAGE  = EXC_STAGE_DEF,
    parameter int SQUASH_CYC = SQUASH_CYC_DEF,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_valid,
    input  logic [STAGES-1:0] stall_req,
    input  logic              except,
    output logic [STAGES-1:0] stage_stall,
    output logic [STAGES-1:0] stage_flush,
    output logic [STAGES-1:0] stage_valid,
    output logic              retire,
    output logic [CNT_W-1:0]  perf_stall,
    output logic [CNT_W-1:0]  perf_flush,
    output logic [CNT_W-1:0]  perf_retire
);

    localparam int FLUSH_TOP = min_int(EXC_STAGE + 1, STAGES - 1);

    pipe_state_t         r_state;
    logic [SQ_CNT_W-1:0] r_sq_cnt;
    logic [STAGES-1:0]   r_valid;

    logic [STAGES-1:0]   w_suffix;
    logic [STAGES-1:0]   w_stall;
    logic [STAGES-1:0]   w_flush;
    logic [STAGES-1:0]   w_prev;
    logic                w_blocked;
    logic                w_accept;
    logic                w_retire;

    // A stalled stage backs up every stage in front of it.
    always_comb begin
        logic acc;
        acc      = 1'b0;
        w_suffix = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            acc         = acc | stall_req[i];
            w_suffix[i] = acc;
        end
    end

    assign w_blocked = w_suffix[EXC_STAGE+1];
    assign w_accept  = (r_state == RUN) && except && !w_blocked;

    always_comb begin
        w_stall = w_suffix;
        w_flush = '0;
        if (w_accept) begin
            for (int i = 0; i <= FLUSH_TOP; i++) w_stall[i] = 1'b0;
        end
        for (int i = 1; i < STAGES; i++) w_flush[i] = w_stall[i-1] & ~w_stall[i];
        if (w_accept) begin
            for (int i = 0; i <= FLUSH_TOP; i++) w_flush[i] = 1'b1;
        end
        if (r_state == SQUASH) w_flush[1] = 1'b1;
        if (rst) begin
            w_stall = '0;
            w_flush = '1;
        end
    end

    assign w_prev = {r_valid[STAGES-2:0], fetch_valid};

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_valid
            always_ff @(posedge clk) begin
                if (rst || w_flush[gi]) begin
                    r_valid[gi] <= 1'b0;
                end else if (!w_stall[gi]) begin
                    r_valid[gi] <= w_prev[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= RUN;
            r_sq_cnt <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_accept) begin
                        r_state  <= SQUASH;
                        r_sq_cnt <= SQ_CNT_W'(SQUASH_CYC - 1);
                    end
                end
                SQUASH: begin
                    if (r_sq_cnt == '0) r_state <= RUN;
                    else                r_sq_cnt <= r_sq_cnt - 1'b1;
                end
                default: r_state <= RUN;
            endcase
        end
    end

    assign w_retire    = r_valid[STAGES-1] & ~stall_req[STAGES-1] & ~w_flush[STAGES-1];
    assign retire      = w_retire;
    assign stage_stall = w_stall;
    assign stage_flush = w_flush;
    assign stage_valid = r_valid;

`ifdef PIPE_CTRL_PERF_EN
    pipe_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk          (clk),
        .rst          (rst),
        .i_inc_stall  (w_stall[0]),
        .i_inc_flush  (w_accept),
        .i_inc_retire (w_retire),
        .o_stall_cnt  (perf_stall),
        .o_flush_cnt  (perf_flush),
        .o_retire_cnt (perf_retire)
    );
`else
    assign perf_stall  = '0;
    assign perf_flush  = '0;
    assign perf_retire = '0;
`endif

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter STAGES, default 5: pipeline stage count; legal range 3..8.
REQ-002 Parameter EXC_STAGE, default 3: stage index where exceptions resolve; legal range 1..STAGES-2.
REQ-003 Parameter SQUASH_CYC, default 1: post-exception squash length in cycles; legal range 1..4.
REQ-004 Parameter CNT_W, default 32: performance counter width.
REQ-005 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port fetch_valid, input, 1: stage 0 holds a real instruction.
REQ-008 Port stall_req, input, STAGES: stage i cannot complete this cycle.
REQ-009 Port except, input, 1: instruction in EXC_STAGE raises an exception.
REQ-010 Ports stage_stall and stage_flush, output, STAGES each: hold or clear the entry register of stage i; stage_stall[0] and stage_flush[0] act on the PC.
REQ-011 Port stage_valid, output, STAGES: the stage holds a non-bubble instruction.
REQ-012 Port retire, output, 1: an instruction leaves stage STAGES-1 this cycle.
REQ-013 Ports perf_stall, perf_flush and perf_retire, output, CNT_W each: performance counters.

Function
REQ-014 The block SHALL drive stage_stall[i] combinationally as the OR of stall_req[j] for j>=i, unless an override in REQ-016 applies.
REQ-015 The block SHALL assert stage_flush[i] for i>=1 when stage_stall[i-1]=1 and stage_stall[i]=0, inserting a bubble.
REQ-016 An exception is accepted when the FSM is in RUN, except=1, and stall_req[j]=0 for all j>EXC_STAGE; in that cycle, for every i<=min(EXC_STAGE+1, STAGES-1), stage_flush[i]=1 and stage_stall[i]=0.
REQ-017 If except=1 while any stall_req[j]=1 for j>EXC_STAGE, the exception is not accepted; REQ-014 applies and the request is re-evaluated each cycle.
REQ-018 The FSM SHALL have two states: RUN and SQUASH.
  - RUN to SQUASH on an accepted exception, loading sq_cnt with SQUASH_CYC-1.
  - SQUASH decrements sq_cnt each cycle.
  - SQUASH to RUN in the cycle where sq_cnt=0.
REQ-019 In SQUASH the block SHALL force stage_flush[1]=1, ignore except, and otherwise apply REQ-014 and REQ-015.
REQ-020 stage_valid SHALL update as follows:
  - stage_valid[0] <= fetch_valid when stage 0 is not stalled.
  - stage_valid[i] <= stage_valid[i-1] when stage i is not stalled.
  - A flush loads 0; flush wins over stall.
  - A stall holds the current value.
REQ-021 The block SHALL drive retire = stage_valid[STAGES-1] & ~stall_req[STAGES-1] & ~stage_flush[STAGES-1] on the same cycle, with zero latency.
REQ-022 Simultaneous stall_req bits SHALL be treated only through the OR rule of REQ-014; no priority among them.

Reset
REQ-023 While rst=1, the block SHALL:
  - set the FSM to RUN;
  - set sq_cnt, stage_valid and all perf counters to 0;
  - drive stage_flush to all ones, stage_stall to 0 and retire to 0.
REQ-024 A reset asserted mid-SQUASH or mid-stall SHALL abandon that operation; the cycle after rst falls behaves as RUN with an empty pipe.

Configuration
REQ-025 Macro PIPE_CTRL_PERF_EN, when defined, SHALL enable the perf counters:
  - perf_stall increments each cycle stage_stall[0]=1.
  - perf_flush increments on each accepted exception.
  - perf_retire increments when retire=1.
  - All three wrap modulo 2^CNT_W.
REQ-026 Without PIPE_CTRL_PERF_EN, the perf outputs SHALL be constant 0 and no counter flops SHALL be synthesised.

Structure
REQ-027 The shared package SHALL hold the pipe_state_t enum (RUN, SQUASH) and the default values of STAGES, EXC_STAGE and SQUASH_CYC.
REQ-028 The counters SHALL live in one sub-module, pipe_perf_cnt, instantiated only under PIPE_CTRL_PERF_EN.

Verification
All scenarios use STAGES=5, EXC_STAGE=3 and SQUASH_CYC=1 unless noted.
REQ-029 Steady state: fetch_valid=1 for 10 cycles -> stage_valid reaches 5'b11111 by cycle 5; retire=1 from cycle 5; no stall or flush asserted.
REQ-030 Single stall: stall_req=5'b00100 for 2 cycles -> stage_stall=5'b00111 and stage_flush=5'b01000 in both cycles; stage_valid[3] is 0 in the following cycle.
REQ-031 Exception:
  - except=1 with stall_req=0 -> stage_flush=5'b11111, stage_stall=0, state goes to SQUASH.
  - Next cycle: stage_flush[1]=1 and except is ignored.
  - Cycle after that: state returns to RUN.
REQ-032 Blocked exception: except=1 with stall_req=5'b10000 for 3 cycles -> no flush and stage_stall=5'b11111 during those cycles; the flush occurs on the first cycle stall_req[4]=0.
REQ-033 Reset mid-squash: set SQUASH_CYC=3; assert rst in the second SQUASH cycle -> next cycle state=RUN, stage_valid=0, and perf counters=0 when PIPE_CTRL_PERF_EN is defined.
REQ-034 Counter wrap: set CNT_W=4 and retire 17 instructions -> perf_retire=1; without the macro all perf outputs read 0.
